cpu_pc_arbiter: RTL and testbench
=================================

Name: cpu_pc_arbiter

Overview:
- Merges PC requests from N_CHANNELS producer ports into one buffered output stream toward a single CPU/engine consumer.
- Each port carries the usual PC handshake: pc_valid, pc, refer_to_char and pc_ready.
- Arbitration is round-robin, with one push per cycle into a FWFT FIFO of FIFO_DEPTH entries.
- Each entry is tagged with its source channel. This lets several execution units feed one shared PC queue without losing requests.

Parameters:
- PC_WIDTH, 8, width of a program counter.
- N_CHANNELS, 4, number of producer ports; must be >= 2.
- FIFO_DEPTH, 4, output queue entries; must be a power of 2 and >= 2.
- CH_W, max(1,$clog2(N_CHANNELS)), width of the channel tag; derived, not overridden.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the occupancy count; derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_pc_valid  in  N_CHANNELS  per-channel request valid.
- in_pc  in  N_CHANNELS*PC_WIDTH  per-channel PC; channel i occupies bits [i*PC_WIDTH +: PC_WIDTH].
- in_refer_to_char  in  N_CHANNELS  per-channel refer_to_char flag.
- in_pc_ready  out  N_CHANNELS  per-channel accept.
- out_pc_valid  out  1  FIFO head valid.
- out_pc  out  PC_WIDTH  head PC.
- out_refer_to_char  out  1  head flag.
- out_channel  out  CH_W  source channel of the head entry.
- out_pc_ready  in  1  consumer accept.
- fifo_count  out  CNT_W  current occupancy.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Handshake: a transfer occurs on any port in a cycle where valid & ready are both high.
  - A producer holds valid, pc and flag stable until its transfer.
  - The grant is not locked: it may move to another channel while a request waits.
- Grant: combinational from in_pc_valid, an rr_ptr register and the FIFO full flag.
  - The search starts at (rr_ptr+1) mod N_CHANNELS and takes the first valid channel.
  - in_pc_ready[i] = !rst & !full & (grant==i) & in_pc_valid[i]. At most one bit is high per cycle.
  - rr_ptr <= granted channel only on an accepted push; otherwise rr_ptr holds.
- Push: write {pc, refer_to_char, channel} at wr_ptr; wr_ptr wraps modulo FIFO_DEPTH.
- Pop: occurs when out_pc_valid & out_pc_ready; rd_ptr wraps modulo FIFO_DEPTH.
- Output: FWFT from the head entry.
  - out_pc_valid = (count != 0).
  - When out_pc_valid=0, out_pc, out_refer_to_char and out_channel are forced to 0.
- Latency: an accepted push is visible at the output on the next cycle; minimum input-to-output latency is 1 cycle.
- Count rules:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full: when count == FIFO_DEPTH, no push is accepted, even if a pop occurs in the same cycle. All in_pc_ready are 0.
- Empty: pop cannot occur; out_pc_valid=0. A push into an empty FIFO raises out_pc_valid on the next cycle.
- Reset values:
  - rd_ptr=0, wr_ptr=0, count=0.
  - rr_ptr=N_CHANNELS-1, so channel 0 wins first.
  - out_pc_valid=0, all outputs 0, in_pc_ready=0 while rst is high.
  - Storage is not reset.
- Reset mid-operation: all queued entries are discarded. An in-flight handshake in the reset cycle is not accepted.
- Ordering: strict FIFO across all channels. Per-channel order is preserved.

Optional Feature:
- Macro: CPU_ARB_CHAR_PRIORITY_EN.
- When defined:
  - Arbitration has two levels. The round-robin search first considers only channels with in_pc_valid & in_refer_to_char.
  - If none qualify, it falls back to round-robin over all valid channels.
  - rr_ptr is shared between both levels and updated as above.
- When undefined: pure round-robin; in_refer_to_char does not affect the grant.

Test Plan:
- Single request after reset: ch2 valid, pc=0x15, flag=1; out_pc_ready=1. Response:
  - in_pc_ready[2]=1 in the same cycle.
  - Next cycle: out_pc_valid=1, out_pc=0x15, out_refer_to_char=1, out_channel=2.
  - The following cycle: out_pc_valid=0, count=0.
- Fairness: all 4 channels continuously valid with pc=0x10+i; out_pc_ready=1. Response:
  - Accept order is ch0,1,2,3,0,1… with one grant per cycle.
  - Output order matches, delayed by 1 cycle.
- Full/back-pressure: out_pc_ready=0; ch1 streams pc 1..6 with FIFO_DEPTH=4. Response:
  - 4 accepts, then in_pc_ready=0 and count=4.
  - Raise out_pc_ready for one cycle: pop 1, with no push in that same cycle.
  - Next cycle: pc 5 is accepted.
- Wrap-around and simultaneous push/pop: stream 10 PCs with out_pc_ready=1 while the FIFO holds 2 entries. Response:
  - count stays 2.
  - Pointers wrap.
  - Output sequence is exact, with no loss or duplication.
- Reset mid-operation: fill 3 entries, then pulse rst for 1 cycle with ch0 valid. Response:
  - No accept in the reset cycle.
  - count=0 and out_pc_valid=0 after reset.
  - ch0 is accepted in the first post-reset cycle.
- CPU_ARB_CHAR_PRIORITY_EN: ch0 flag=0 and ch3 flag=1 both valid; rr_ptr at reset. Response:
  - With the macro: ch3 is granted first.
  - Without the macro: ch0 is granted first.

Source files
------------

// File: rtl/cpu_pc_arbiter.sv
// cpu_pc_arbiter
// Merges PC requests from N_CHANNELS producer ports into one first-word-fall-through
// queue feeding a single CPU/engine consumer. Producers are served round-robin, with
// at most one push per cycle. Each queued entry remembers which channel it came from.
//
// Ports:
//   clk                rising-edge clock
//   rst                synchronous reset, active-high
//   in_pc_valid        per-channel request valid
//   in_pc              per-channel PC, channel i at [i*PC_WIDTH +: PC_WIDTH]
//   in_refer_to_char   per-channel refer_to_char flag
//   in_pc_ready        per-channel accept (at most one bit high)
//   out_pc_valid       queue head valid
//   out_pc             head PC (0 when the queue is empty)
//   out_refer_to_char  head flag (0 when the queue is empty)
//   out_channel        source channel of the head (0 when the queue is empty)
//   out_pc_ready       consumer accept
//   fifo_count         current queue occupancy
//
// Optional build macro:
//   CPU_ARB_CHAR_PRIORITY_EN - when defined, channels raising refer_to_char win
//   arbitration over the others. Round-robin order still applies within whichever
//   group is selected.

module cpu_pc_arbiter #(
    parameter int PC_WIDTH   = 8,
    parameter int N_CHANNELS = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W  = ($clog2(N_CHANNELS) > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CHANNELS-1:0]        in_pc_valid,
    input  logic [N_CHANNELS*PC_WIDTH-1:0] in_pc,
    input  logic [N_CHANNELS-1:0]        in_refer_to_char,
    output logic [N_CHANNELS-1:0]        in_pc_ready,
    output logic                         out_pc_valid,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic                         out_refer_to_char,
    output logic [CH_W-1:0]              out_channel,
    input  logic                         out_pc_ready,
    output logic [CNT_W-1:0]             fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       scan_idx;
    logic                  grant_found;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [N_CHANNELS-1:0] candidates;
    logic [PC_WIDTH-1:0]   push_pc;
    logic                  push_flag;

    logic [PC_WIDTH-1:0]   mem_pc   [FIFO_DEPTH];
    logic                  mem_flag [FIFO_DEPTH];
    logic [CH_W-1:0]       mem_ch   [FIFO_DEPTH];

    assign full = (count == CNT_W'(FIFO_DEPTH));

    // Channels eligible for the grant this cycle. With character priority enabled,
    // flagged requests take precedence. The full set of valid channels is used only
    // when no valid channel carries the flag.
    always_comb begin
        candidates = in_pc_valid;
`ifdef CPU_ARB_CHAR_PRIORITY_EN
        if ((in_pc_valid & in_refer_to_char) != '0) begin
            candidates = in_pc_valid & in_refer_to_char;
        end
`endif
    end

    // Round-robin search. It starts one past the last channel that was actually
    // pushed and takes the first eligible channel. The grant is recomputed every
    // cycle, so a waiting request can lose its slot to a different channel.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 1; k <= N_CHANNELS; k++) begin
            scan_idx = CH_W'((int'(rr_ptr) + k) % N_CHANNELS);
            if (!grant_found && candidates[scan_idx]) begin
                grant       = scan_idx;
                grant_found = 1'b1;
            end
        end
    end

    // Only the granted channel sees ready. Ready is suppressed while the queue is
    // full, even if the consumer is popping in the same cycle, and during reset.
    always_comb begin
        in_pc_ready = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            in_pc_ready[i] = !rst && !full && grant_found &&
                             (grant == CH_W'(i)) && in_pc_valid[i];
        end
    end

    // Select the payload of the granted channel for writing into the queue.
    always_comb begin
        push_pc   = '0;
        push_flag = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (grant == CH_W'(i)) begin
                push_pc   = in_pc[i*PC_WIDTH +: PC_WIDTH];
                push_flag = in_refer_to_char[i];
            end
        end
    end

    assign push = |in_pc_ready;
    assign pop  = out_pc_valid && out_pc_ready;

    // Queue storage. It is deliberately left out of reset, because the count and
    // pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= push_pc;
            mem_flag[wr_ptr] <= push_flag;
            mem_ch[wr_ptr]   <= grant;
        end
    end

    // Pointer, occupancy and arbitration state. rr_ptr resets to the last channel so
    // that channel 0 is first in line. It advances only when a push really happens.
    // The depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr_ptr <= CH_W'(N_CHANNELS - 1);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= grant;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // First-word-fall-through head. The payload outputs are forced to zero whenever
    // the queue holds nothing, so stale storage never leaks out.
    assign out_pc_valid      = (count != '0);
    assign out_pc            = out_pc_valid ? mem_pc[rd_ptr]   : '0;
    assign out_refer_to_char = out_pc_valid ? mem_flag[rd_ptr] : 1'b0;
    assign out_channel       = out_pc_valid ? mem_ch[rd_ptr]   : '0;
    assign fifo_count        = count;

endmodule

// File: tb/tb_cpu_pc_arbiter.sv
// tb_cpu_pc_arbiter
// Scoreboard bench for cpu_pc_arbiter.
//
// The stimulus side predicts which channel should be accepted on each cycle, using
// a plain round-robin model. It queues the expected entry when the clock edge
// arrives. A separate monitor runs mid-cycle. It compares the queue head, the
// valid flag and the occupancy count, and it retires entries when the consumer
// takes them.
//
// The bench honours CPU_ARB_CHAR_PRIORITY_EN in the same way as the design.

module tb_cpu_pc_arbiter;

    localparam int PC_WIDTH   = 8;
    localparam int N_CHANNELS = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = 2;
    localparam int CNT_W      = 3;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                flag;
        logic [CH_W-1:0]     ch;
    } entry_t;

    logic                                 clk;
    logic                                 rst;
    logic [N_CHANNELS-1:0]                in_pc_valid;
    logic [N_CHANNELS-1:0][PC_WIDTH-1:0]  req_pc;
    logic [N_CHANNELS-1:0]                in_refer_to_char;
    logic [N_CHANNELS-1:0]                in_pc_ready;
    logic                                 out_pc_valid;
    logic [PC_WIDTH-1:0]                  out_pc;
    logic                                 out_refer_to_char;
    logic [CH_W-1:0]                      out_channel;
    logic                                 out_pc_ready;
    logic [CNT_W-1:0]                     fifo_count;

    entry_t exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     model_rr = N_CHANNELS - 1;
    logic   mon_en = 1'b0;

    cpu_pc_arbiter #(
        .PC_WIDTH   (PC_WIDTH),
        .N_CHANNELS (N_CHANNELS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_pc_valid       (in_pc_valid),
        .in_pc             (req_pc),
        .in_refer_to_char  (in_refer_to_char),
        .in_pc_ready       (in_pc_ready),
        .out_pc_valid      (out_pc_valid),
        .out_pc            (out_pc),
        .out_refer_to_char (out_refer_to_char),
        .out_channel       (out_channel),
        .out_pc_ready      (out_pc_ready),
        .fifo_count        (fifo_count)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value. Every comparison in the
    // bench goes through here, so the counters always stay consistent.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h time=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Present a request on one producer port.
    task automatic setReq(input int ch, input logic v, input logic [PC_WIDTH-1:0] pc,
                          input logic flag);
        in_pc_valid[CH_W'(ch)]      = v;
        req_pc[CH_W'(ch)]           = pc;
        in_refer_to_char[CH_W'(ch)] = flag;
    endtask

    // Once a channel has been served, its producer goes idle.
    task automatic dropGrant(input int g);
        if (g >= 0) in_pc_valid[CH_W'(g)] = 1'b0;
    endtask

    // Reference arbitration rule. The search starts one past the last channel
    // served and takes the first requester. If character priority is enabled and
    // any requester carries the flag, only flagged requesters are considered.
    function automatic int modelGrant();
        logic [N_CHANNELS-1:0] cand;
        logic [CH_W-1:0]       c;
        cand = in_pc_valid;
`ifdef CPU_ARB_CHAR_PRIORITY_EN
        if ((in_pc_valid & in_refer_to_char) != '0) cand = in_pc_valid & in_refer_to_char;
`endif
        for (int k = 1; k <= N_CHANNELS; k++) begin
            c = CH_W'((model_rr + k) % N_CHANNELS);
            if (cand[c]) return int'(c);
        end
        return -1;
    endfunction

    // Run one clock cycle.
    // The task is entered 2 units after a rising edge. It drives rst and
    // out_pc_ready, then predicts and checks the accept vector. At the next rising
    // edge it updates the model queue and the round-robin pointer. It returns the
    // expected grant, or -1 when no channel should be accepted.
    task automatic applyStimulus(input logic r, input logic ordy, output int g);
        logic [N_CHANNELS-1:0] exp_ready;
        entry_t                e;
        rst          = r;
        out_pc_ready = ordy;
        #1;
        g = (r || exp_q.size() >= FIFO_DEPTH) ? -1 : modelGrant();
        exp_ready = (g >= 0) ? (N_CHANNELS'(1) << g) : '0;
        checkOutput("in_pc_ready", 32'(in_pc_ready), 32'(exp_ready));
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            model_rr = N_CHANNELS - 1;
        end else if (g >= 0) begin
            e.pc   = req_pc[CH_W'(g)];
            e.flag = in_refer_to_char[CH_W'(g)];
            e.ch   = CH_W'(g);
            exp_q.push_back(e);
            model_rr = g;
        end
        #2;
    endtask

    // Mid-cycle monitor. It compares the outputs with the scoreboard and retires
    // the head entry whenever the consumer takes it. Checks are skipped while reset
    // is discarding a non-empty queue, because the queue contents are about to be
    // dropped.
    always @(negedge clk) begin
        entry_t head;
        if (mon_en && !(rst && exp_q.size() != 0)) begin
            checkOutput("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
            checkOutput("out_pc_valid", 32'(out_pc_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                checkOutput("empty_out_pc", 32'(out_pc), 32'(0));
                checkOutput("empty_out_flag", 32'(out_refer_to_char), 32'(0));
                checkOutput("empty_out_channel", 32'(out_channel), 32'(0));
            end else begin
                head = exp_q[0];
                checkOutput("out_pc", 32'(out_pc), 32'(head.pc));
                checkOutput("out_refer_to_char", 32'(out_refer_to_char), 32'(head.flag));
                checkOutput("out_channel", 32'(out_channel), 32'(head.ch));
                if (out_pc_valid && out_pc_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Directed scenarios, then a randomized soak, then a drain and the summary.
    initial begin
        int g;
        int nxt;
        rst              = 1'b1;
        out_pc_ready     = 1'b0;
        in_pc_valid      = '0;
        req_pc           = '0;
        in_refer_to_char = '0;
        @(posedge clk);
        #2;
        mon_en = 1'b1;

        in_pc_valid = '1;
        applyStimulus(1'b1, 1'b1, g);
        in_pc_valid = '0;

        // Single request from channel 2, seen at the output one cycle later.
        setReq(2, 1'b1, 8'h15, 1'b1);
        applyStimulus(1'b0, 1'b1, g);
        dropGrant(g);
        repeat (2) applyStimulus(1'b0, 1'b1, g);

        // Fairness: all channels request continuously.
        applyStimulus(1'b1, 1'b1, g);
        for (int i = 0; i < N_CHANNELS; i++) setReq(i, 1'b1, 8'(8'h10 + i), 1'b0);
        repeat (12) applyStimulus(1'b0, 1'b1, g);
        in_pc_valid = '0;
        repeat (3) applyStimulus(1'b0, 1'b1, g);

        // Fill to full with back-pressure. A single pop does not admit a push in
        // the same cycle; the next request is taken one cycle later.
        applyStimulus(1'b1, 1'b0, g);
        nxt = 1;
        setReq(1, 1'b1, 8'(nxt), 1'b0);
        repeat (6) begin
            applyStimulus(1'b0, 1'b0, g);
            if (g == 1) begin nxt++; setReq(1, nxt <= 6, 8'(nxt), 1'b0); end
        end
        applyStimulus(1'b0, 1'b1, g);
        applyStimulus(1'b0, 1'b0, g);
        if (g == 1) begin nxt++; setReq(1, nxt <= 6, 8'(nxt), 1'b0); end
        repeat (8) begin
            applyStimulus(1'b0, 1'b1, g);
            if (g == 1) begin nxt++; setReq(1, nxt <= 6, 8'(nxt), 1'b0); end
        end

        // Steady push and pop with two entries held, long enough to wrap pointers.
        applyStimulus(1'b1, 1'b0, g);
        nxt = 8'h20;
        setReq(0, 1'b1, 8'(nxt), 1'b0);
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, c >= 2, g);
            if (g == 0) begin nxt++; setReq(0, 1'b1, 8'(nxt), nxt[0]); end
        end
        in_pc_valid = '0;
        repeat (4) applyStimulus(1'b0, 1'b1, g);

        // Reset while three entries are queued and channel 0 is still requesting.
        applyStimulus(1'b1, 1'b0, g);
        nxt = 8'h40;
        setReq(0, 1'b1, 8'(nxt), 1'b0);
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, g);
            if (g == 0) begin nxt++; setReq(0, 1'b1, 8'(nxt), 1'b0); end
        end
        applyStimulus(1'b1, 1'b0, g);
        applyStimulus(1'b0, 1'b1, g);
        in_pc_valid = '0;
        repeat (3) applyStimulus(1'b0, 1'b1, g);

        // Channel 0 unflagged against channel 3 flagged, straight after reset.
        applyStimulus(1'b1, 1'b0, g);
        setReq(0, 1'b1, 8'h30, 1'b0);
        setReq(3, 1'b1, 8'h33, 1'b1);
        applyStimulus(1'b0, 1'b1, g);
        dropGrant(g);
        applyStimulus(1'b0, 1'b1, g);
        dropGrant(g);
        repeat (3) applyStimulus(1'b0, 1'b1, g);

        // Randomized traffic, consumer stalls and occasional resets.
        applyStimulus(1'b1, 1'b1, g);
        repeat (2000) begin
            for (int ch = 0; ch < N_CHANNELS; ch++) begin
                if (!in_pc_valid[CH_W'(ch)] && $urandom_range(0, 1) == 1)
                    setReq(ch, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
            end
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, g);
            dropGrant(g);
        end
        in_pc_valid = '0;
        repeat (8) applyStimulus(1'b0, 1'b1, g);
        checkOutput("final_count", 32'(fifo_count), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
